// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_e;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_NINE = 4'd9;
   localparam digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/done operation bus between a controller (master) and the BCD unit (slave).
interface bcd_serial_addsub_if #(
   parameter int unsigned DIGITS = 4
) ();

   logic                  start;
   logic                  sub;
   logic                  cin;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   s;
   logic                  cout;
   logic                  neg;
   logic                  err;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, s, cout, neg, err
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, s, cout, neg, err
   );

endinterface

// File: rtl/bcd_digit_add.sv
// One BCD digit: x + y + carry-in, corrected by +6 when the binary sum exceeds 9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  digit_t i_x,
   input  digit_t i_y,
   input  logic   i_ci,
   output digit_t o_d,
   output logic   o_co
);

   logic [4:0] w_sum;

   always_comb begin
      w_sum = {1'b0, i_x} + {1'b0, i_y} + {4'b0000, i_ci};
      o_co  = (w_sum > 5'd9);
      o_d   = o_co ? (w_sum[3:0] + BCD_CORR) : w_sum[3:0];
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract, LSD first; negative differences get a
// second nines-complement pass so s is always a magnitude.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_serial_addsub_if.slave   bus
);

   localparam int unsigned W     = 4 * DIGITS;
   localparam int unsigned IDX_W = $clog2(DIGITS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_e            r_state, w_state_nxt;
   logic [W-1:0]      r_a, r_b, r_s;
   logic [IDX_W-1:0]  r_idx;
   logic              r_sub, r_carry, r_cout, r_neg, r_err;

   digit_t            w_x, w_y, w_dig;
   logic              w_co, w_last;

   function automatic logic has_bad(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i +: 4] > BCD_NINE) bad = 1'b1;
      end
      return bad;
   endfunction

   // Operands are shifted right each cycle, so digit [3:0] is always the current one.
   always_comb begin
      w_x = r_a[3:0];
      w_y = r_sub ? (BCD_NINE - r_b[3:0]) : r_b[3:0];
      if (r_state == FIX) begin
         w_x = BCD_NINE - r_s[3:0];
         w_y = '0;
      end
   end

   bcd_digit_add u_digit_add (
      .i_x  (w_x),
      .i_y  (w_y),
      .i_ci (r_carry),
      .o_d  (w_dig),
      .o_co (w_co)
   );

   assign w_last = (r_idx == LAST_IDX);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = ADD;
         ADD:     if (w_last) w_state_nxt = (r_sub && !w_co) ? FIX : DONE;
         FIX:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = bus.start ? ADD : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_idx   <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_neg   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_sub   <= bus.sub;
                  r_carry <= bus.sub | bus.cin;
                  r_idx   <= '0;
                  r_err   <= has_bad(bus.a) | has_bad(bus.b);
               end
            end
            ADD: begin
               r_a     <= r_a >> 4;
               r_b     <= r_b >> 4;
               r_s     <= W'({w_dig, r_s} >> 4);
               r_carry <= w_co;
               r_idx   <= r_idx + IDX_W'(1);
               if (w_last) begin
                  r_idx   <= '0;
                  r_carry <= 1'b1;
                  r_cout  <= w_co;
                  r_neg   <= r_sub & ~w_co;
               end
            end
            FIX: begin
               r_s     <= W'({w_dig, r_s} >> 4);
               r_carry <= w_co;
               r_idx   <= r_idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state == ADD) || (r_state == FIX);
   assign bus.done = (r_state == DONE);
   assign bus.s    = r_s;
   assign bus.cout = r_cout;
   assign bus.neg  = r_neg;
   assign bus.err  = r_err;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub with DIGITS=4; latency is the index of
// the clock edge (start edge = 0) at which done=1 is sampled.
module tb_bcd_serial_addsub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_serial_addsub_if #(.DIGITS(4)) bus ();

   bcd_serial_addsub #(.DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int lat;
   bit busy_after, done_after;

   // Call at a negedge; returns at the negedge where done=1 is first seen.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tsub, input logic tcin, input bit poke);
      bus.a = ta; bus.b = tb_v; bus.sub = tsub; bus.cin = tcin; bus.start = 1'b1;
      @(posedge clk); #1;
      busy_after = bus.busy;
      done_after = bus.done;
      bus.start  = 1'b0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (poke && n == 2) begin
            bus.start = 1'b1; bus.a = 16'h9999; bus.sub = 1'b0;
         end
         if (poke && n == 4) bus.start = 1'b0;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.cout, bus.neg, bus.err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {bus.busy, bus.done, bus.cout, bus.neg, bus.err});
      end
      checks++;
      if (bus.s !== 16'h0000) begin
         failures++; $display("FAIL reset_s got=%h exp=0000", bus.s);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      run_op(16'h1234, 16'h8766, 1'b0, 1'b0, 1'b0);
      checks++;
      if (busy_after !== 1'b1) begin
         failures++; $display("FAIL add_busy_at_start got=%b exp=1", busy_after);
      end
      checks++;
      if (lat != 5) begin failures++; $display("FAIL add_latency got=%0d exp=5", lat); end
      checks++;
      if ({bus.s, bus.cout, bus.neg} !== {16'h0000, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL add_1234_8766 got s=%h cout=%b neg=%b exp s=0000 cout=1 neg=0",
                  bus.s, bus.cout, bus.neg);
      end
      run_op(16'h0999, 16'h0000, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({bus.s, bus.cout} !== {16'h1000, 1'b0}) begin
         failures++;
         $display("FAIL add_0999_cin got s=%h cout=%b exp s=1000 cout=0", bus.s, bus.cout);
      end
      run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({bus.s, bus.cout, bus.err} !== {16'h9999, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL add_9999_9999 got s=%h cout=%b err=%b exp s=9999 cout=1 err=0",
                  bus.s, bus.cout, bus.err);
      end
   endtask

   task automatic test_sub();
      run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
      checks++;
      if (lat != 5) begin failures++; $display("FAIL sub_pos_latency got=%0d exp=5", lat); end
      checks++;
      if ({bus.s, bus.cout, bus.neg} !== {16'h3766, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_5000_1234 got s=%h cout=%b neg=%b exp s=3766 cout=1 neg=0",
                  bus.s, bus.cout, bus.neg);
      end
      run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({bus.s, bus.cout, bus.neg} !== {16'h0000, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_equal got s=%h cout=%b neg=%b exp s=0000 cout=1 neg=0",
                  bus.s, bus.cout, bus.neg);
      end
   endtask

   task automatic test_sub_neg_busy();
      run_op(16'h1234, 16'h5000, 1'b1, 1'b0, 1'b1);
      checks++;
      if (lat != 9) begin failures++; $display("FAIL sub_neg_latency got=%0d exp=9", lat); end
      checks++;
      if ({bus.s, bus.cout, bus.neg} !== {16'h3766, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL sub_1234_5000 got s=%h cout=%b neg=%b exp s=3766 cout=0 neg=1",
                  bus.s, bus.cout, bus.neg);
      end
   endtask

   task automatic test_back_to_back();
      run_op(16'h1234, 16'h5000, 1'b1, 1'b0, 1'b0);
      // Still in the DONE cycle: issue the next operation right here.
      run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({busy_after, done_after} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0",
                  busy_after, done_after);
      end
      checks++;
      if (lat != 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
      checks++;
      if ({bus.s, bus.neg} !== {16'h3766, 1'b0}) begin
         failures++;
         $display("FAIL b2b_result got s=%h neg=%b exp s=3766 neg=0", bus.s, bus.neg);
      end
   endtask

   task automatic test_err();
      run_op(16'h00A1, 16'h0000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (lat != 5) begin failures++; $display("FAIL err_latency got=%0d exp=5", lat); end
      checks++;
      if (bus.err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", bus.err); end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy, bus.err} !== 3'b001) begin
         failures++;
         $display("FAIL err_after_done got done=%b busy=%b err=%b exp done=0 busy=0 err=1",
                  bus.done, bus.busy, bus.err);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      bus.a = 16'h5000; bus.b = 16'h1234; bus.sub = 1'b1; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.s, bus.cout, bus.neg, bus.err} !== 21'b0) begin
         failures++;
         $display("FAIL rst_mid_outputs got busy=%b done=%b s=%h cout=%b neg=%b err=%b exp 0",
                  bus.busy, bus.done, bus.s, bus.cout, bus.neg, bus.err);
      end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      checks++;
      if (dones != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
      run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({bus.s, bus.cout, bus.neg, bus.err} !== {16'h3766, 1'b1, 1'b0, 1'b0} || lat != 5) begin
         failures++;
         $display("FAIL rst_mid_recover got s=%h cout=%b neg=%b err=%b lat=%0d exp 3766/1/0/0/5",
                  bus.s, bus.cout, bus.neg, bus.err, lat);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
      test_reset();
      test_add();
      test_sub();
      test_sub_neg_busy();
      test_back_to_back();
      test_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Digit-serial, parametrised multi-digit BCD adder/subtractor. It is the successor to the single-digit BCD adder: it processes DIGITS packed-BCD digits one per clock, least-significant digit first, and adds a subtract mode. Subtract results are returned as sign plus magnitude, with an automatic recomplement pass. It sits behind a start/done handshake so a controller can issue back-to-back decimal operations.

## Interface
Parameters:
- DIGITS, default 4, number of BCD digits per operand (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  operation request; sampled only when busy=0.
- sub  in  1  mode: 0 = a+b+cin, 1 = a−b.
- cin  in  1  decimal carry-in; used in add mode only, ignored when sub=1.
- a  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0].
- b  in  4*DIGITS  packed BCD operand.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: results valid.
- s  out  4*DIGITS  packed BCD result (magnitude in sub mode).
- cout  out  1  add mode: final decimal carry. Sub mode: 1 = no borrow (a≥b).
- neg  out  1  sub mode, a<b; always 0 in add mode.
- err  out  1  at least one input digit of a or b was >9.

## Operation
- States: IDLE, ADD, FIX, DONE.
- IDLE: when start=1, latch a, b, sub and cin, clear the digit index, go to ADD. err is computed from the latched operands at this point.
- ADD: one digit per cycle, processing a[i] + (sub ? 9−b[i] : b[i]) + carry.
  - Initial carry is cin in add mode and 1 in sub mode.
  - Digit correction: if the binary sum is >9, add 6 and set carry.
  - The digit result is written into s[i].
  - After digit DIGITS−1:
    - Add mode, or sub mode with final carry=1: cout=final carry, neg=0, go to DONE.
    - Sub mode with final carry=0: cout=0, neg=1, go to FIX.
- FIX: recomplement pass, one digit per cycle: s[i] ← (9−s[i]) + carry, initial carry 1, same correction rule. The final carry is discarded. Go to DONE after the last digit.
- DONE: done=1 for one cycle, busy=0, return to IDLE. s, cout, neg and err hold until the next accepted start.
- Invalid digits (>9) are processed with the same correction rule and the same timing; s is then unspecified and err=1.
- Magnitude result range is 0…10^DIGITS−1. Add overflow is reported only through cout.

## Timing
- Reset values: busy=0, done=0, s=0, cout=0, neg=0, err=0, state IDLE.
- If start is sampled at edge 0:
  - busy=1 from edge 0.
  - ADD digit i is resolved at edge i+1.
- Latency from the start edge to done=1:
  - Add mode, and sub mode with a≥b: DIGITS+1 cycles.
  - Sub mode with a<b: 2·DIGITS+1 cycles.
- busy falls at the edge that asserts done.
- start while busy=1 is ignored, with no queueing.
- start during the DONE cycle is accepted, because busy=0 there. The next operation begins at that edge and done stays a single pulse.
- Result registers change only during ADD and FIX. Intermediate values are visible while busy=1 and are not valid.
- rst asserted mid-operation aborts immediately to the reset values. No done pulse is emitted.

## Structure
- Package bcd_pkg:
  - state enum (IDLE, ADD, FIX, DONE).
  - BCD_NINE = 4'd9 and BCD_CORR = 4'd6 constants.
  - digit type (4-bit).
- Sub-module bcd_digit_add: combinational 4-bit + 4-bit + carry-in with >9 correction, producing a digit and carry-out.
  - A single instance is shared by ADD and FIX through an operand mux.
- Top level contains the FSM, the digit index counter (width $clog2(DIGITS)+1), the carry flop, and the operand/result shift or indexed registers.

## Test plan
All scenarios use DIGITS=4.
- Add 1234 + 8766, cin=0 → s=0000, cout=1, neg=0; done 5 cycles after start.
- Add 0999 + 0000, cin=1 → s=1000, cout=0; then 9999 + 9999, cin=1 → s=9999, cout=1.
- Sub 5000 − 1234 → s=3766, cout=1, neg=0, latency 5; sub 1234 − 1234 → s=0000, neg=0.
- Sub 1234 − 5000 → s=3766, neg=1, cout=0, latency 9. Start pulses issued while busy are ignored; start in the DONE cycle begins a new operation.
- a=00A1 → err=1 with normal latency. rst pulsed at digit 2 → all outputs 0, no done pulse; the next start completes correctly.
